// File: rtl/clk_enable_pkg.sv
// Shared types and reset defaults for the clock-enable generator.
// Per-channel tables cover the largest legal channel count.
package clk_enable_pkg;

  localparam int CNT_W_DEF = 8;
  localparam int MAX_CH    = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PHASE = 2'd1,
    ST_RUN   = 2'd2
  } ch_state_e;

  // ch0 is the fast non-inverted domain; every other channel divides by 4 inverted
  localparam int DEF_HALF  [MAX_CH] = '{0: 1, default: 2};
  localparam int DEF_PHASE [MAX_CH] = '{default: 0};
  localparam bit DEF_INV   [MAX_CH] = '{0: 1'b0, default: 1'b1};

endpackage

// File: rtl/clk_enable_gen_if.sv
// Configuration write port: one-cycle write strobe plus registered reject pulse.
interface clk_enable_gen_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
);
  localparam int CH_W = $clog2(NUM_CH);

  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_half;
  logic [CNT_W-1:0] cfg_phase;
  logic             cfg_inv;
  logic             cfg_err;

  modport master (
    output cfg_we, cfg_ch, cfg_half, cfg_phase, cfg_inv,
    input  cfg_err
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_half, cfg_phase, cfg_inv,
    output cfg_err
  );

endinterface

// File: rtl/clk_enable_ch.sv
// One divided-clock channel: IDLE/PHASE/RUN counter, active and pending config, edge ticks.
// All outputs are flops; a write lands one cycle later, or at the next 1->0 boundary while running.
module clk_enable_ch
  import clk_enable_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int INIT_HALF  = 1,
  parameter int INIT_PHASE = 0,
  parameter bit INIT_INV   = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run_i,
  input  logic             run_rise_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] wr_half_i,
  input  logic [CNT_W-1:0] wr_phase_i,
  input  logic             wr_inv_i,
  output logic             clk_out_o,
  output logic             tick_rise_o,
  output logic             tick_fall_o,
  output logic             in_run_o,
  output logic             pend_o
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] half_q, half_d, phase_q, phase_d;
  logic [CNT_W-1:0] p_half_q, p_half_d, p_phase_q, p_phase_d;
  logic             lvl_q, lvl_d, inv_q, inv_d, p_inv_q, p_inv_d, pend_q, pend_d;
  logic             clk_q, clk_d, rise_q, rise_d, fall_q, fall_d;
  logic             apply_pend;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lvl_d      = lvl_q;
    half_d     = half_q;
    phase_d    = phase_q;
    inv_d      = inv_q;
    p_half_d   = p_half_q;
    p_phase_d  = p_phase_q;
    p_inv_d    = p_inv_q;
    pend_d     = pend_q;
    apply_pend = 1'b0;

    if (!run_i) begin
      state_d    = ST_IDLE;
      cnt_d      = '0;
      lvl_d      = 1'b0;
      apply_pend = pend_q;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (run_rise_i) begin
            cnt_d   = '0;
            lvl_d   = 1'b0;
            state_d = (phase_q != '0) ? ST_PHASE : ST_RUN;
          end
        end
        ST_PHASE: begin
          if ((phase_q <= ONE) || (cnt_q >= phase_q - ONE)) begin
            lvl_d   = 1'b1;
            cnt_d   = '0;
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        ST_RUN: begin
          // >= keeps the count bounded even if half has just shrunk
          if (cnt_q >= half_q - ONE) begin
            lvl_d      = ~lvl_q;
            cnt_d      = '0;
            apply_pend = pend_q & lvl_q;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (apply_pend) begin
      half_d  = p_half_q;
      phase_d = p_phase_q;
      inv_d   = p_inv_q;
      pend_d  = 1'b0;
    end

    // Ordered after the boundary apply so a coincident write becomes the next pending value
    if (wr_i) begin
      if ((state_q == ST_IDLE) || !run_i) begin
        half_d  = wr_half_i;
        phase_d = wr_phase_i;
        inv_d   = wr_inv_i;
      end else begin
        p_half_d  = wr_half_i;
        p_phase_d = wr_phase_i;
        p_inv_d   = wr_inv_i;
        pend_d    = 1'b1;
      end
    end

    clk_d  = lvl_d ^ inv_d;
    rise_d = run_i & clk_d & ~clk_q;
    fall_d = run_i & ~clk_d & clk_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      lvl_q     <= 1'b0;
      half_q    <= CNT_W'(INIT_HALF);
      phase_q   <= CNT_W'(INIT_PHASE);
      inv_q     <= INIT_INV;
      p_half_q  <= '0;
      p_phase_q <= '0;
      p_inv_q   <= 1'b0;
      pend_q    <= 1'b0;
      clk_q     <= INIT_INV;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lvl_q     <= lvl_d;
      half_q    <= half_d;
      phase_q   <= phase_d;
      inv_q     <= inv_d;
      p_half_q  <= p_half_d;
      p_phase_q <= p_phase_d;
      p_inv_q   <= p_inv_d;
      pend_q    <= pend_d;
      clk_q     <= clk_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
    end
  end

  assign clk_out_o   = clk_q;
  assign tick_rise_o = rise_q;
  assign tick_fall_o = fall_q;
  assign in_run_o    = (state_q == ST_RUN);
  assign pend_o      = pend_q;

endmodule

// File: rtl/clk_enable_gen.sv
// Generates NUM_CH programmable divided clocks with rise/fall enable ticks from one master clock.
// Outputs registered; config writes are never stalled, illegal ones are dropped and flagged by cfg_err.
module clk_enable_gen
  import clk_enable_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run_i,
  clk_enable_gen_if.slave   cfg,
  output logic [NUM_CH-1:0] clk_out_o,
  output logic [NUM_CH-1:0] tick_rise_o,
  output logic [NUM_CH-1:0] tick_fall_o,
  output logic              locked_o
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int CH_W1 = CH_W + 1;
  localparam logic [CH_W:0] NUM_CH_L = CH_W1'(NUM_CH);

  logic              run_q, err_q, locked_q;
  logic              err_d, locked_d, run_rise, wr_ok;
  logic [NUM_CH-1:0] in_run, pend;

  always_comb begin
    run_rise = run_i & ~run_q;
    err_d    = cfg.cfg_we & ((cfg.cfg_half == '0) | ({1'b0, cfg.cfg_ch} >= NUM_CH_L));
    wr_ok    = cfg.cfg_we & ~err_d;
    locked_d = run_i & (&in_run) & ~(|pend);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      run_q    <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      run_q    <= run_i;
      err_q    <= err_d;
      locked_q <= locked_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_enable_ch #(
      .CNT_W      (CNT_W),
      .INIT_HALF  (DEF_HALF[g]),
      .INIT_PHASE (DEF_PHASE[g]),
      .INIT_INV   (DEF_INV[g])
    ) u_ch (
      .clock       (clock),
      .reset       (reset),
      .run_i       (run_i),
      .run_rise_i  (run_rise),
      .wr_i        (wr_ok && (cfg.cfg_ch == CH_W'(g))),
      .wr_half_i   (cfg.cfg_half),
      .wr_phase_i  (cfg.cfg_phase),
      .wr_inv_i    (cfg.cfg_inv),
      .clk_out_o   (clk_out_o[g]),
      .tick_rise_o (tick_rise_o[g]),
      .tick_fall_o (tick_fall_o[g]),
      .in_run_o    (in_run[g]),
      .pend_o      (pend[g])
    );
  end

  assign cfg.cfg_err = err_q;
  assign locked_o    = locked_q;

endmodule

// File: tb/tb_clk_enable_gen.sv
// Directed scenarios followed by random traffic, all checked against a segment-countdown model.
// Five channels so that an out-of-range channel select is representable.
module tb_clk_enable_gen;

  localparam int NUM_CH = 5;
  localparam int CNT_W  = 8;
  localparam int CH_W   = $clog2(NUM_CH);

  logic              clock = 1'b0;
  logic              reset, run_i;
  logic [NUM_CH-1:0] clk_out_o, tick_rise_o, tick_fall_o;
  logic              locked_o;

  clk_enable_gen_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) cfg_if ();

  clk_enable_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .run_i       (run_i),
    .cfg         (cfg_if),
    .clk_out_o   (clk_out_o),
    .tick_rise_o (tick_rise_o),
    .tick_fall_o (tick_fall_o),
    .locked_o    (locked_o)
  );

  always #5 clock = ~clock;

  // Model: each channel is a sequence of constant-level segments; m_left counts down what remains.
  int                m_half [NUM_CH], m_phase [NUM_CH], m_left [NUM_CH];
  int                m_ph [NUM_CH], m_pp [NUM_CH];
  bit                m_inv [NUM_CH], m_pi [NUM_CH], m_p [NUM_CH];
  bit                m_on [NUM_CH], m_inph [NUM_CH], m_lvl [NUM_CH];
  logic [NUM_CH-1:0] m_out, m_tr, m_tf;
  bit                m_locked, m_err, m_run_prev;
  int                checks, fails;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_half[i]  = (i == 0) ? 1 : 2;
      m_phase[i] = 0;
      m_inv[i]   = (i != 0);
      m_p[i]     = 1'b0;
      m_on[i]    = 1'b0;
      m_inph[i]  = 1'b0;
      m_lvl[i]   = 1'b0;
      m_left[i]  = 0;
      m_out[i]   = m_inv[i];
    end
    m_tr = '0; m_tf = '0; m_locked = 1'b0; m_err = 1'b0; m_run_prev = 1'b0;
  endtask

  task automatic m_apply(input int i);
    m_half[i] = m_ph[i]; m_phase[i] = m_pp[i]; m_inv[i] = m_pi[i]; m_p[i] = 1'b0;
  endtask

  task automatic model_step();
    bit lk, was_on, prev, wr;
    if (reset) begin
      model_reset();
      return;
    end
    lk = run_i;
    for (int i = 0; i < NUM_CH; i++)
      if (!m_on[i] || m_inph[i] || m_p[i]) lk = 1'b0;
    m_err = cfg_if.cfg_we && (int'(cfg_if.cfg_half) == 0 || int'(cfg_if.cfg_ch) >= NUM_CH);
    for (int i = 0; i < NUM_CH; i++) begin
      was_on = m_on[i];
      prev   = m_out[i];
      if (!run_i) begin
        m_on[i] = 1'b0; m_inph[i] = 1'b0; m_lvl[i] = 1'b0;
        if (m_p[i]) m_apply(i);
      end else if (!m_on[i]) begin
        if (!m_run_prev) begin
          m_on[i]  = 1'b1;
          m_lvl[i] = 1'b0;
          m_inph[i] = (m_phase[i] != 0);
          m_left[i] = (m_phase[i] != 0) ? m_phase[i] : m_half[i];
        end
      end else begin
        m_left[i]--;
        if (m_left[i] == 0) begin
          if (m_inph[i]) begin
            m_inph[i] = 1'b0;
            m_lvl[i]  = 1'b1;
          end else begin
            if (m_lvl[i] && m_p[i]) m_apply(i);
            m_lvl[i] = !m_lvl[i];
          end
          m_left[i] = m_half[i];
        end
      end
      wr = cfg_if.cfg_we && !m_err && (int'(cfg_if.cfg_ch) == i);
      if (wr) begin
        if (!was_on || !run_i) begin
          m_half[i] = int'(cfg_if.cfg_half); m_phase[i] = int'(cfg_if.cfg_phase); m_inv[i] = cfg_if.cfg_inv;
        end else begin
          m_ph[i] = int'(cfg_if.cfg_half); m_pp[i] = int'(cfg_if.cfg_phase); m_pi[i] = cfg_if.cfg_inv;
          m_p[i]  = 1'b1;
        end
      end
      m_out[i] = m_lvl[i] ^ m_inv[i];
      m_tr[i]  = run_i && m_out[i] && !prev;
      m_tf[i]  = run_i && !m_out[i] && prev;
    end
    m_locked   = lk;
    m_run_prev = run_i;
  endtask

  task automatic cyc();
    model_step();
    @(posedge clock);
    @(negedge clock);
    chk("clk_out",   32'(clk_out_o),      32'(m_out));
    chk("tick_rise", 32'(tick_rise_o),    32'(m_tr));
    chk("tick_fall", 32'(tick_fall_o),    32'(m_tf));
    chk("locked",    32'(locked_o),       32'(m_locked));
    chk("cfg_err",   32'(cfg_if.cfg_err), 32'(m_err));
  endtask

  task automatic setcfg(input bit we, input int ch, input int half, input int phase, input bit inv);
    cfg_if.cfg_we    = we;
    cfg_if.cfg_ch    = CH_W'(ch);
    cfg_if.cfg_half  = CNT_W'(half);
    cfg_if.cfg_phase = CNT_W'(phase);
    cfg_if.cfg_inv   = inv;
  endtask

  initial begin
    int n, c, viol, len, exp_bit;
    bit drop, back, first, last, prev, new_run;
    checks = 0; fails = 0;
    reset = 1'b1; run_i = 1'b0;
    setcfg(0, 0, 1, 0, 0);
    model_reset();
    @(negedge clock);
    cyc(); cyc();
    chk("rst_clk_out", 32'(clk_out_o), 32'h1E);
    chk("rst_ticks", 32'(tick_rise_o | tick_fall_o), 32'h0);
    chk("rst_locked", 32'(locked_o), 32'h0);
    reset = 1'b0;
    cyc(); cyc();

    // Defaults: ch0 period 2, ch1 starts high with period 4, lock within 2 cycles
    run_i = 1'b1;
    cyc();
    chk("t1_ch1_start", 32'(clk_out_o[1]), 32'h1);
    cyc();
    chk("t1_locked", 32'(locked_o), 32'h1);
    n = 0;
    repeat (8) begin
      cyc();
      if (tick_rise_o[0]) n++;
    end
    chk("t1_rise0_count", 32'(n), 32'd4);

    // Phase 5 then 3 high / 3 low on ch2
    run_i = 1'b0;
    cyc();
    setcfg(1, 2, 3, 5, 0);
    cyc();
    setcfg(0, 0, 1, 0, 0);
    run_i = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      cyc();
      exp_bit = (k <= 5) ? 0 : ((((k - 6) / 3) % 2 == 0) ? 1 : 0);
      chk("t2_wave", 32'(clk_out_o[2]), 32'(exp_bit));
    end

    // Live change of ch1 to half 1: lock drops and returns, no runt or stretched pulse
    setcfg(1, 1, 1, 0, 1);
    cyc();
    setcfg(0, 0, 1, 0, 0);
    drop = 0; back = 0; viol = 0; len = 0; first = 1; last = clk_out_o[1];
    for (c = 0; c < 40 && !back; c++) begin
      cyc();
      if (!locked_o) drop = 1;
      else if (drop) back = 1;
      if (clk_out_o[1] == last) len++;
      else begin
        if (!first && (len < 1 || len > 2)) viol++;
        first = 0; last = clk_out_o[1]; len = 1;
      end
    end
    chk("t3_locked_dropped", 32'(drop), 32'h1);
    chk("t3_locked_returned", 32'(back), 32'h1);
    chk("t3_pulse_width", 32'(viol), 32'h0);

    // Rejected writes
    setcfg(1, 0, 0, 0, 0);
    cyc();
    setcfg(0, 0, 1, 0, 0);
    chk("t4_err_half0", 32'(cfg_if.cfg_err), 32'h1);
    cyc();
    chk("t4_err_clear", 32'(cfg_if.cfg_err), 32'h0);
    setcfg(1, 5, 3, 0, 0);
    cyc();
    setcfg(0, 0, 1, 0, 0);
    chk("t4_err_ch5", 32'(cfg_if.cfg_err), 32'h1);
    cyc();
    chk("t4_err_clear2", 32'(cfg_if.cfg_err), 32'h0);
    prev = clk_out_o[0];
    repeat (4) begin
      cyc();
      chk("t4_ch0_toggle", 32'(clk_out_o[0]), 32'(!prev));
      prev = clk_out_o[0];
    end

    // Abort ch2 mid-period, then restart must repeat the 5-cycle phase
    c = 0;
    while (!clk_out_o[2] && c < 20) begin
      cyc();
      c++;
    end
    chk("t5_ch2_high_seen", 32'(clk_out_o[2]), 32'h1);
    cyc();
    run_i = 1'b0;
    cyc();
    chk("t5_abort_level", 32'(clk_out_o[2]), 32'h0);
    chk("t5_abort_ticks", 32'(tick_rise_o | tick_fall_o), 32'h0);
    cyc(); cyc();
    run_i = 1'b1;
    n = 0; c = 0;
    do begin
      cyc();
      if (!clk_out_o[2]) n++;
      c++;
    end while (!clk_out_o[2] && c < 20);
    chk("t5_phase_delay", 32'(n), 32'd5);

    // Reset with a pending write: defaults come back and the pending value is lost
    setcfg(1, 1, 3, 0, 0);
    cyc();
    setcfg(0, 0, 1, 0, 0);
    cyc();
    reset = 1'b1;
    cyc();
    chk("t6_rst_clk_out", 32'(clk_out_o), 32'h1E);
    reset = 1'b0;
    n = 0; c = 0;
    do begin
      cyc();
      if (clk_out_o[1]) n++;
      c++;
    end while (clk_out_o[1] && c < 20);
    chk("t6_ch1_default_half", 32'(n), 32'd2);

    // Random traffic; no writes on a run rising edge
    repeat (600) begin
      new_run = ($urandom_range(0, 19) != 0) ? run_i : !run_i;
      reset   = ($urandom_range(0, 199) == 0);
      setcfg(($urandom_range(0, 3) == 0), $urandom_range(0, 7), $urandom_range(0, 5),
             $urandom_range(0, 6), 1'($urandom_range(0, 1)));
      if (new_run && !m_run_prev) cfg_if.cfg_we = 1'b0;
      run_i = new_run;
      cyc();
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
